control_pipe: RTL and testbench

CONTROL_PIPE -- requirements
Module: control_pipe

---
 rtl/control_pipe.sv | 177 +++++++++++++++++
 tb/tb_control_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_pipe.sv
// Purpose : decode an opcode into a control bundle and carry it through the
//           Execute, Memory and Writeback stage registers of a 5-stage core.
// Latency : Decode->Execute 1 cycle, ->Memory 2 cycles, ->Writeback 3 cycles.
// Backpr. : stallD or a taken branch (PCSrcE) inserts a bubble into Execute;
//           the Memory and Writeback stages never stall.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   opcodeD, validD       Decode-stage opcode and its valid qualifier
//   stallD                hazard stall: Decode holds, Execute gets a bubble
//   PCSrcE                taken branch resolved in Execute
//   opcodeE, PCSE, regWE, memWriteSrcE, flagUpdateE, illegalE
//                         Execute-stage control bundle
//   regWM, memWriteM      Memory-stage write enables
//   regWW                 Writeback-stage register write enable
//   flushD                combinational copy of PCSrcE for Fetch/Decode
//   branchCnt             taken-branch counter, only when CTRL_PERF_CNT_EN
//
// Build option: define CTRL_PERF_CNT_EN to add the 16-bit taken-branch
// counter and its branchCnt output port.

module control_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  opcodeD,
    input  logic        validD,
    input  logic        stallD,
    input  logic        PCSrcE,
    output logic [3:0]  opcodeE,
    output logic        PCSE,
    output logic        regWE,
    output logic        memWriteSrcE,
    output logic        flagUpdateE,
    output logic        regWM,
    output logic        memWriteM,
    output logic        regWW,
    output logic        flushD,
    output logic        illegalE
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [15:0] branchCnt
`endif
);

    typedef struct packed {
        logic pcs;
        logic regw;
        logic memws;
        logic flag;
        logic illegal;
    } ctrl_t;

    typedef struct packed {
        logic [3:0] opcode;
        ctrl_t      ctrl;
    } ex_t;

    localparam logic [3:0] OP_NOP = 4'b0111;
    localparam ctrl_t      CTRL_NONE = '0;
    localparam ex_t        EX_BUBBLE = '{opcode: OP_NOP, ctrl: CTRL_NONE};

    // Zero-flag based write suppression lives in the condition logic, so
    // this block never suppresses on its own.
    localparam logic FLAG_SUPPRESS = 1'b0;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    ctrl_t dec_ctrl;

    always_comb begin
        dec_ctrl = CTRL_NONE;
        case (opcodeD)
            4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
                dec_ctrl.regw = 1'b1;
                dec_ctrl.flag = 1'b1;
            end
            4'b0100: dec_ctrl.regw  = 1'b1;    // load
            4'b0101: dec_ctrl.memws = 1'b1;    // store
            4'b0110: dec_ctrl.flag  = 1'b1;    // compare
            4'b0111: dec_ctrl       = CTRL_NONE; // nop
            4'b1000, 4'b1001: dec_ctrl.pcs = 1'b1; // branch / branch-not-equal
            default: dec_ctrl.illegal = 1'b1;  // 1010-1111 undefined
        endcase
    end

    // ------------------------------------------------------------------
    // Execute register
    // ------------------------------------------------------------------
    ex_t ex_d, ex_q;

    always_comb begin
        ex_d = EX_BUBBLE;
        // A taken branch squashes the wrong-path Decode instruction; a stall
        // or an invalid Decode slot also injects a bubble. All three collapse
        // into the same single bubble when they coincide.
        if (!PCSrcE && !stallD && validD) begin
            ex_d.opcode = opcodeD;
            ex_d.ctrl   = dec_ctrl;
        end
    end

    // ------------------------------------------------------------------
    // Memory register
    // ------------------------------------------------------------------
    logic regw_m_d, regw_m_q;
    logic memw_m_d, memw_m_q;

    always_comb begin
        // Illegal instructions decode with no writes; the extra gate keeps
        // that guarantee local to the stage that commits the enables.
        regw_m_d = ex_q.ctrl.regw  & ~PCSrcE & ~FLAG_SUPPRESS & ~ex_q.ctrl.illegal;
        memw_m_d = ex_q.ctrl.memws & ~PCSrcE & ~FLAG_SUPPRESS & ~ex_q.ctrl.illegal;
    end

    // ------------------------------------------------------------------
    // Writeback register
    // ------------------------------------------------------------------
    logic regw_w_d, regw_w_q;

    always_comb begin
        regw_w_d = regw_m_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q     <= EX_BUBBLE;
            regw_m_q <= 1'b0;
            memw_m_q <= 1'b0;
            regw_w_q <= 1'b0;
        end else begin
            ex_q     <= ex_d;
            regw_m_q <= regw_m_d;
            memw_m_q <= memw_m_d;
            regw_w_q <= regw_w_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional taken-branch counter
    // ------------------------------------------------------------------
`ifdef CTRL_PERF_CNT_EN
    logic [15:0] branch_cnt_d, branch_cnt_q;

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        if (PCSrcE) begin
            branch_cnt_d = branch_cnt_q + 16'd1;  // natural wrap at 0xFFFF
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_cnt_q <= 16'd0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
        end
    end

    assign branchCnt = branch_cnt_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign opcodeE      = ex_q.opcode;
    assign PCSE         = ex_q.ctrl.pcs;
    assign regWE        = ex_q.ctrl.regw;
    assign memWriteSrcE = ex_q.ctrl.memws;
    assign flagUpdateE  = ex_q.ctrl.flag;
    assign illegalE     = ex_q.ctrl.illegal;
    assign regWM        = regw_m_q;
    assign memWriteM    = memw_m_q;
    assign regWW        = regw_w_q;
    assign flushD       = PCSrcE;

endmodule

// File: tb/tb_control_pipe.sv
`timescale 1ns/1ps
module tb_control_pipe;

    logic        clk;
    logic        reset;
    logic [3:0]  opcodeD;
    logic        validD;
    logic        stallD;
    logic        PCSrcE;
    logic [3:0]  opcodeE;
    logic        PCSE, regWE, memWriteSrcE, flagUpdateE;
    logic        regWM, memWriteM, regWW, flushD, illegalE;
`ifdef CTRL_PERF_CNT_EN
    logic [15:0] branchCnt;
`endif

    control_pipe dut (
        .clk          (clk),
        .reset        (reset),
        .opcodeD      (opcodeD),
        .validD       (validD),
        .stallD       (stallD),
        .PCSrcE       (PCSrcE),
        .opcodeE      (opcodeE),
        .PCSE         (PCSE),
        .regWE        (regWE),
        .memWriteSrcE (memWriteSrcE),
        .flagUpdateE  (flagUpdateE),
        .regWM        (regWM),
        .memWriteM    (memWriteM),
        .regWW        (regWW),
        .flushD       (flushD),
        .illegalE     (illegalE)
`ifdef CTRL_PERF_CNT_EN
        ,
        .branchCnt    (branchCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drv(input logic [3:0] op, input logic v, input logic s, input logic p);
        opcodeD = op;
        validD  = v;
        stallD  = s;
        PCSrcE  = p;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One vector: Decode inputs and the Execute bundle they must produce.
    typedef struct {
        logic [3:0] op;
        logic       vld;
        logic       stl;
        logic [3:0] e_op;
        logic       e_pcs, e_regw, e_memws, e_flag, e_ill;
    } vec_t;

    typedef struct packed {
        logic [3:0] op;
        logic       pcs, regw, memws, flag, ill;
    } exp_e_t;

    vec_t   vecs[20];
    exp_e_t eq[$];
    logic [1:0] mq[$];
    logic   wq[$];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_e_t    ee;
        logic [1:0] me;
        logic      we;

        //        op     vld   stl   e_op   pcs  regw memws flag ill
        vecs[0]  = '{4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{4'h1, 1'b1, 1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{4'h2, 1'b1, 1'b0, 4'h2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{4'h3, 1'b1, 1'b0, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{4'h4, 1'b1, 1'b0, 4'h4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'h5, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{4'h6, 1'b1, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{4'h7, 1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'h8, 1'b1, 1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'h9, 1'b1, 1'b0, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'hA, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{4'hB, 1'b1, 1'b0, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{4'hC, 1'b1, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{4'hD, 1'b1, 1'b0, 4'hD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{4'hE, 1'b1, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{4'hF, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{4'h0, 1'b0, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{4'h4, 1'b1, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{4'h5, 1'b0, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{4'h0, 1'b0, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // ---------------- reset state ----------------
        drv(4'h0, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_opcodeE", {12'd0, opcodeE}, 16'h7);
        chk("rst_bits", {7'd0, PCSE, regWE, memWriteSrcE, flagUpdateE, regWM,
                         memWriteM, regWW, illegalE}, 16'h0);
`ifdef CTRL_PERF_CNT_EN
        chk("rst_branchCnt", branchCnt, 16'h0);
`endif
        step();
        chk("rst_hold_opcodeE", {12'd0, opcodeE}, 16'h7);
        #2 reset = 1'b1;

        // ---------------- table-driven scoreboard ----------------
        mq.push_back(2'b00);
        wq.push_back(1'b0);
        wq.push_back(1'b0);
        for (int i = 0; i < 20; i++) begin
            drv(vecs[i].op, vecs[i].vld, vecs[i].stl, 1'b0);
            eq.push_back('{vecs[i].e_op, vecs[i].e_pcs, vecs[i].e_regw,
                           vecs[i].e_memws, vecs[i].e_flag, vecs[i].e_ill});
            mq.push_back({vecs[i].e_regw, vecs[i].e_memws});
            wq.push_back(vecs[i].e_regw);
            step();
            ee = eq.pop_front();
            me = mq.pop_front();
            we = wq.pop_front();
            chk($sformatf("v%0d_E", i),
                {7'd0, opcodeE, PCSE, regWE, memWriteSrcE, flagUpdateE, illegalE},
                {7'd0, ee.op, ee.pcs, ee.regw, ee.memws, ee.flag, ee.ill});
            chk($sformatf("v%0d_M", i), {14'd0, regWM, memWriteM}, {14'd0, me});
            chk($sformatf("v%0d_W", i), {15'd0, regWW}, {15'd0, we});
        end
        eq.delete();
        mq.delete();
        wq.delete();

        // ---------------- throughput 0000,0100,0101 ----------------
        drv(4'h0, 1'b1, 1'b0, 1'b0); step();
        chk("thr_c1_regWE", {15'd0, regWE}, 16'd1);
        drv(4'h4, 1'b1, 1'b0, 1'b0); step();
        chk("thr_c2_regWE", {15'd0, regWE}, 16'd1);
        drv(4'h5, 1'b1, 1'b0, 1'b0); step();
        chk("thr_c3_regWE", {15'd0, regWE}, 16'd0);
        chk("thr_c3_regWW", {15'd0, regWW}, 16'd1);
        drv(4'h7, 1'b0, 1'b0, 1'b0); step();
        chk("thr_c4_memWriteM", {15'd0, memWriteM}, 16'd1);
        chk("thr_c4_regWW", {15'd0, regWW}, 16'd1);
        step();
        chk("thr_c5_memWriteM", {15'd0, memWriteM}, 16'd0);
        chk("thr_c5_regWW", {15'd0, regWW}, 16'd0);

        // ---------------- stall for two cycles ----------------
        drv(4'h0, 1'b1, 1'b1, 1'b0); step();
        chk("stall1_E", {11'd0, opcodeE, regWE}, {11'd0, 4'h7, 1'b0});
        step();
        chk("stall2_E", {11'd0, opcodeE, regWE}, {11'd0, 4'h7, 1'b0});
        drv(4'h0, 1'b1, 1'b0, 1'b0); step();
        chk("stall_rel_E", {10'd0, opcodeE, regWE, flagUpdateE}, {10'd0, 4'h0, 1'b1, 1'b1});

        // ---------------- flush of a store behind a branch ----------------
        drv(4'h8, 1'b1, 1'b0, 1'b0); step();
        chk("br_E", {11'd0, opcodeE, PCSE}, {11'd0, 4'h8, 1'b1});
        drv(4'h5, 1'b1, 1'b0, 1'b1); #1;
        chk("flushD_hi", {15'd0, flushD}, 16'd1);
        step();
        chk("flush_E", {11'd0, opcodeE, memWriteSrcE}, {11'd0, 4'h7, 1'b0});
        drv(4'h7, 1'b0, 1'b0, 1'b0); #1;
        chk("flushD_lo", {15'd0, flushD}, 16'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("flush_memWriteM_%0d", k), {15'd0, memWriteM}, 16'd0);
        end

        // ---------------- back-to-back branches ----------------
        drv(4'h8, 1'b1, 1'b0, 1'b0); step();
        drv(4'h9, 1'b1, 1'b0, 1'b1); step();
        chk("br2_squash", {11'd0, opcodeE, PCSE}, {11'd0, 4'h7, 1'b0});

        // ---------------- flush and stall together: one bubble ----------------
        drv(4'h0, 1'b1, 1'b1, 1'b1); #1;
        chk("fs_flushD", {15'd0, flushD}, 16'd1);
        step();
        chk("fs_bubble", {11'd0, opcodeE, regWE}, {11'd0, 4'h7, 1'b0});
        drv(4'h0, 1'b1, 1'b0, 1'b0); step();
        chk("fs_resume", {11'd0, opcodeE, regWE}, {11'd0, 4'h0, 1'b1});

        // ---------------- PCSrcE gates Memory-stage capture ----------------
        drv(4'h7, 1'b0, 1'b0, 1'b1); step();
        chk("gate_regWM", {15'd0, regWM}, 16'd0);
        drv(4'h7, 1'b0, 1'b0, 1'b0); step();
        chk("gate_regWW", {15'd0, regWW}, 16'd0);

        // ---------------- illegal opcode ----------------
        drv(4'hC, 1'b1, 1'b0, 1'b0); step();
        chk("ill_E", {12'd0, illegalE, regWE, memWriteSrcE, PCSE}, {12'd0, 4'b1000});
        drv(4'h7, 1'b0, 1'b0, 1'b0); step();
        chk("ill_M", {14'd0, regWM, memWriteM}, 16'd0);
        step();
        chk("ill_W", {15'd0, regWW}, 16'd0);

        // ---------------- reset mid-pipeline with a store in flight ----------------
        drv(4'h5, 1'b1, 1'b0, 1'b0); step();
        step();
        chk("pre_rst_memWriteM", {14'd0, memWriteSrcE, memWriteM}, 16'h3);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_opcodeE", {12'd0, opcodeE}, 16'h7);
        chk("mid_rst_writes", {12'd0, memWriteSrcE, memWriteM, regWM, regWW}, 16'h0);
        #1 reset = 1'b1;
        drv(4'h0, 1'b1, 1'b0, 1'b0); step();
        chk("post_rst_regWE", {15'd0, regWE}, 16'd1);
        chk("post_rst_memWriteM", {15'd0, memWriteM}, 16'd0);
        drv(4'h7, 1'b0, 1'b0, 1'b0);

`ifdef CTRL_PERF_CNT_EN
        // ---------------- branch counter wrap ----------------
        #2 reset = 1'b0;
        #1;
        chk("cnt_rst", branchCnt, 16'h0);
        #1 reset = 1'b1;
        drv(4'h7, 1'b0, 1'b0, 1'b1);
        repeat (16'hFFFE) @(posedge clk);
        #1;
        chk("cnt_fffe", branchCnt, 16'hFFFE);
        step();
        chk("cnt_ffff", branchCnt, 16'hFFFF);
        step();
        chk("cnt_wrap", branchCnt, 16'h0000);
        step();
        chk("cnt_0001", branchCnt, 16'h0001);
        drv(4'h7, 1'b0, 1'b0, 1'b0); step();
        chk("cnt_hold", branchCnt, 16'h0001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
